// File: rtl/duck_wave_ctrl.sv
// Duck Hunt wave/round flow controller: bird release, shot budget,
// hit scoring with perfect-wave bonus, escape counting and game end.
module duck_wave_ctrl #(
    parameter int NUM_BIRDS       = 2,
    parameter int SHOTS_PER_WAVE  = 3,
    parameter int MISS_LIMIT      = 3,
    parameter int WAVES_PER_ROUND = 5,
    parameter int POINTS_PER_HIT  = 50,
    parameter int PERFECT_BONUS   = 100,
    parameter int SCORE_W         = 16
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 start,
    input  logic                 trigger,
    input  logic [NUM_BIRDS-1:0] bird_hit,
    input  logic [NUM_BIRDS-1:0] bird_flew,
    output logic                 display_start,
    output logic                 release_bird,
    output logic [NUM_BIRDS-1:0] bird_active,
    output logic [3:0]           shots_left,
    output logic [SCORE_W-1:0]   score,
    output logic [7:0]           escapes,
    output logic [7:0]           round,
    output logic                 wave_done,
    output logic                 game_over
);

    typedef enum logic [2:0] {
        IDLE,
        RELEASE,
        FLY,
        RESOLVE,
        CHECK,
        DONE
    } state_t;

    localparam int SUM_W = SCORE_W + 16;
    localparam logic [SUM_W-1:0] SCORE_MAX = {{16{1'b0}}, {SCORE_W{1'b1}}};
    localparam logic [NUM_BIRDS-1:0] ALL_BIRDS = '1;

    state_t state;
    state_t state_nxt;

    logic [NUM_BIRDS-1:0] hits;
    logic [7:0]           wave_cnt;

    logic [NUM_BIRDS-1:0] hit_now;
    logic [NUM_BIRDS-1:0] flew_now;
    logic [NUM_BIRDS-1:0] active_nxt;
    logic [3:0]           shots_nxt;
    logic [SUM_W-1:0]     hit_pts;
    logic [SUM_W-1:0]     bonus;
    logic                 fly_exit;
    logic                 wave_wrap;
    logic                 miss_out;

    function automatic logic [3:0] pop(input logic [NUM_BIRDS-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NUM_BIRDS; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_score(
        input logic [SCORE_W-1:0] s,
        input logic [SUM_W-1:0]   inc
    );
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(s) + inc;
        if (sum > SCORE_MAX) begin
            return '1;
        end
        return sum[SCORE_W-1:0];
    endfunction

    function automatic logic [7:0] sat_esc(
        input logic [7:0] e,
        input logic [3:0] inc
    );
        logic [8:0] sum;
        sum = {1'b0, e} + 9'(inc);
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // A hit wins over a simultaneous fly-away on the same bird.
    always_comb begin
        hit_now    = bird_active & bird_hit;
        flew_now   = bird_active & bird_flew & ~bird_hit;
        active_nxt = bird_active & ~(hit_now | flew_now);
        shots_nxt  = shots_left;
        if (trigger && shots_left != 4'd0) begin
            shots_nxt = shots_left - 4'd1;
        end
        fly_exit  = (active_nxt == '0) || (shots_nxt == 4'd0);
        hit_pts   = SUM_W'(POINTS_PER_HIT) * SUM_W'(pop(hit_now));
        bonus     = (hits == ALL_BIRDS) ? SUM_W'(PERFECT_BONUS) : '0;
        wave_wrap = (wave_cnt + 8'd1) == 8'(WAVES_PER_ROUND);
        miss_out  = escapes >= 8'(MISS_LIMIT);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RELEASE;
            RELEASE: state_nxt = FLY;
            FLY:     if (fly_exit) state_nxt = RESOLVE;
            RESOLVE: state_nxt = CHECK;
            CHECK:   state_nxt = miss_out ? DONE : RELEASE;
            DONE:    if (start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        display_start = (state == IDLE);
        wave_done     = (state == CHECK);
        game_over     = (state == DONE);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            release_bird <= 1'b0;
            bird_active  <= '0;
            shots_left   <= '0;
            score        <= '0;
            escapes      <= '0;
            round        <= '0;
            hits         <= '0;
            wave_cnt     <= '0;
        end else begin
            release_bird <= (state == RELEASE);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        score    <= '0;
                        escapes  <= '0;
                        round    <= '0;
                        wave_cnt <= '0;
                    end
                end
                RELEASE: begin
                    bird_active <= ALL_BIRDS;
                    shots_left  <= 4'(SHOTS_PER_WAVE);
                    hits        <= '0;
                end
                FLY: begin
                    bird_active <= active_nxt;
                    shots_left  <= shots_nxt;
                    hits        <= hits | hit_now;
                    score       <= sat_score(score, hit_pts);
                    escapes     <= sat_esc(escapes, pop(flew_now));
                end
                // Birds still up when the shots run out count as escapes.
                RESOLVE: begin
                    escapes     <= sat_esc(escapes, pop(bird_active));
                    bird_active <= '0;
                    score       <= sat_score(score, bonus);
                end
                CHECK: begin
                    if (!miss_out) begin
                        if (wave_wrap) begin
                            wave_cnt <= '0;
                            round    <= round + 8'd1;
                        end else begin
                            wave_cnt <= wave_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_duck_wave_ctrl.sv
// Bench for duck_wave_ctrl: directed scenarios plus random waves, checked
// against a wave-level score/escape model; a second instance runs SCORE_W=8.
module tb_duck_wave_ctrl;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       start = 1'b0;
    logic       trigger = 1'b0;
    logic [1:0] bird_hit = '0;
    logic [1:0] bird_flew = '0;

    logic       display_start, release_bird, wave_done, game_over;
    logic [1:0] bird_active;
    logic [3:0] shots_left;
    logic [15:0] score;
    logic [7:0] escapes, round;

    logic       display_start8, release_bird8, wave_done8, game_over8;
    logic [1:0] bird_active8;
    logic [3:0] shots_left8;
    logic [7:0] score8, escapes8, round8;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] m_act, m_hits;
    int  m_shots, m_s16, m_s8, m_esc, m_round, m_waves;
    bit  m_exit, m_done;

    always #5 CLK = ~CLK;

    duck_wave_ctrl dut (
        .CLK(CLK), .RESET_N(RESET_N), .start(start), .trigger(trigger),
        .bird_hit(bird_hit), .bird_flew(bird_flew),
        .display_start(display_start), .release_bird(release_bird),
        .bird_active(bird_active), .shots_left(shots_left), .score(score),
        .escapes(escapes), .round(round), .wave_done(wave_done),
        .game_over(game_over)
    );

    duck_wave_ctrl #(.SCORE_W(8), .POINTS_PER_HIT(100)) dut8 (
        .CLK(CLK), .RESET_N(RESET_N), .start(start), .trigger(trigger),
        .bird_hit(bird_hit), .bird_flew(bird_flew),
        .display_start(display_start8), .release_bird(release_bird8),
        .bird_active(bird_active8), .shots_left(shots_left8), .score(score8),
        .escapes(escapes8), .round(round8), .wave_done(wave_done8),
        .game_over(game_over8)
    );

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_clear();
        m_s16 = 0; m_s8 = 0; m_esc = 0; m_round = 0; m_waves = 0;
        m_act = 0; m_hits = 0; m_shots = 0; m_exit = 0; m_done = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        model_clear();
        chk("start_disp", display_start, 0);
        chk("start_rel_early", release_bird, 0);
        chk("start_score", score, 0);
        chk("start_esc", escapes, 0);
        @(posedge CLK); #1;
        m_act = 2'b11; m_shots = 3; m_hits = 0; m_exit = 0;
        chk("start_rel", release_bird, 1);
        chk("start_act", bird_active, m_act);
        chk("start_shots", shots_left, m_shots);
    endtask

    task automatic fly_cycle(input bit t, input logic [1:0] h,
                             input logic [1:0] f);
        logic [1:0] hm, fm;
        trigger = t; bird_hit = h; bird_flew = f;
        @(posedge CLK); #1;
        trigger = 0; bird_hit = 0; bird_flew = 0;
        hm = m_act & h;
        fm = m_act & f & ~h;
        m_act  = m_act & ~hm & ~fm;
        m_hits = m_hits | hm;
        m_s16  = sat(m_s16 + 50 * $countones(hm), 65535);
        m_s8   = sat(m_s8 + 100 * $countones(hm), 255);
        m_esc  = sat(m_esc + $countones(fm), 255);
        if (t && m_shots > 0) m_shots--;
        m_exit = (m_act == 0) || (m_shots == 0);
        chk("fly_act", bird_active, m_act);
        chk("fly_shots", shots_left, m_shots);
        chk("fly_score", score, m_s16);
        chk("fly_score8", score8, m_s8);
        chk("fly_esc", escapes, m_esc);
        chk("fly_rel", release_bird, 0);
        chk("fly_wdone", wave_done, 0);
    endtask

    // Called just after the FLY exit edge; inputs here must be ignored.
    task automatic finish_wave();
        trigger = 1; bird_hit = 2'($urandom); bird_flew = 2'($urandom);
        @(posedge CLK); #1;
        m_esc = sat(m_esc + $countones(m_act), 255);
        m_act = 0;
        if (m_hits == 2'b11) begin
            m_s16 = sat(m_s16 + 100, 65535);
            m_s8  = sat(m_s8 + 100, 255);
        end
        chk("res_wdone", wave_done, 1);
        chk("res_esc", escapes, m_esc);
        chk("res_score", score, m_s16);
        chk("res_score8", score8, m_s8);
        chk("res_act", bird_active, 0);
        m_done = (m_esc >= 3);
        if (!m_done) begin
            m_waves++;
            if (m_waves == 5) begin
                m_waves = 0;
                m_round = (m_round + 1) % 256;
            end
        end
        @(posedge CLK); #1;
        chk("chk_wdone", wave_done, 0);
        chk("chk_round", round, m_round);
        chk("chk_round8", round8, m_round);
        chk("chk_over", game_over, m_done);
        chk("chk_rel", release_bird, 0);
        if (!m_done) begin
            @(posedge CLK); #1;
            m_act = 2'b11; m_shots = 3; m_hits = 0; m_exit = 0;
            chk("rel_pulse", release_bird, 1);
            chk("rel_act", bird_active, m_act);
            chk("rel_shots", shots_left, m_shots);
        end
        trigger = 0; bird_hit = 0; bird_flew = 0;
    endtask

    task automatic leave_done();
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        chk("done_idle_disp", display_start, 1);
        chk("done_idle_over", game_over, 0);
        chk("done_idle_esc", escapes, m_esc);
        chk("done_idle_score", score, m_s16);
    endtask

    initial begin
        logic [1:0] h, f;
        bit t;
        model_clear();
        #12;
        chk("rst_disp", display_start, 1);
        chk("rst_score", score, 0);
        chk("rst_rel", release_bird, 0);
        chk("rst_act", bird_active, 0);
        chk("rst_shots", shots_left, 0);
        chk("rst_over", game_over, 0);
        chk("rst_round", round, 0);
        RESET_N = 1'b1;
        @(posedge CLK); #1;
        chk("idle_disp", display_start, 1);

        // Perfect wave across two cycles, then hit-beats-flew wave.
        do_start();
        fly_cycle(1, 2'b01, 2'b00);
        fly_cycle(1, 2'b10, 2'b00);
        chk("perfect_exit", m_exit, 1);
        finish_wave();
        fly_cycle(1, 2'b01, 2'b01);
        fly_cycle(0, 2'b01, 2'b00);
        fly_cycle(0, 2'b10, 2'b00);
        finish_wave();
        for (int w = 0; w < 3; w++) begin
            fly_cycle(0, 2'b11, 2'b00);
            finish_wave();
        end
        chk("round_after5", round, 1);

        // Asynchronous reset in the middle of a wave.
        fly_cycle(0, 2'b01, 2'b00);
        #3 RESET_N = 1'b0;
        #1;
        model_clear();
        chk("arst_disp", display_start, 1);
        chk("arst_score", score, 0);
        chk("arst_act", bird_active, 0);
        chk("arst_round", round, 0);
        #2 RESET_N = 1'b1;
        @(posedge CLK); #1;
        chk("arst_idle", display_start, 1);

        // Shots exhausted twice: escapes reach the limit.
        do_start();
        for (int i = 0; i < 3; i++) fly_cycle(1, 2'b00, 2'b00);
        finish_wave();
        for (int i = 0; i < 3; i++) fly_cycle(1, 2'b00, 2'b00);
        finish_wave();
        chk("over_flag", game_over, 1);
        chk("over_esc", escapes, 4);
        repeat (3) @(posedge CLK);
        #1;
        chk("over_hold", game_over, 1);
        chk("over_score", score, 0);
        leave_done();
        do_start();

        // Random waves; restart whenever the game ends.
        for (int w = 0; w < 40; w++) begin
            for (int c = 0; c < 40 && !m_exit; c++) begin
                t = (c > 20) || ($urandom_range(0, 3) == 0);
                h = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                f = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                fly_cycle(t, h, f);
            end
            chk("fly_bound", m_exit, 1);
            if (!m_exit) $fatal(1, "wave did not resolve");
            finish_wave();
            if (m_done) begin
                leave_done();
                do_start();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
